// File: rtl/rom_fetch_bridge_if.sv
// Signal bundle between the mapper ROM mux, rom_fetch_bridge and the SDRAM arbiter read port.
// The bridge is the slave. The master modport is the environment: the mapper mux plus the arbiter.
interface rom_fetch_bridge_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce_n;
  logic              rom_oe_n;
  logic              rom_word;
  logic              invalidate;
  logic [DATA_W-1:0] rom_q;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  rom_addr, rom_ce_n, rom_oe_n, rom_word, invalidate, mem_ack, mem_rdata,
    output rom_q, busy, mem_req, mem_addr
  );

  modport master (
    output rom_addr, rom_ce_n, rom_oe_n, rom_word, invalidate, mem_ack, mem_rdata,
    input  rom_q, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/rom_fetch_bridge.sv
// Turns muxed mapper ROM reads into word-aligned req/ack memory reads behind a tagged word buffer.
// Define ROM_PREFETCH_EN to add a second entry that prefetches the next word after each demand fill.
module rom_fetch_bridge #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
) (
  input  logic              mclk,
  input  logic              rst_n,
  rom_fetch_bridge_if.slave bus
);
  localparam int unsigned TAG_W = ADDR_W - 1;

  if (DATA_W != 16) begin : g_bad_data_w
    $error("rom_fetch_bridge: DATA_W must be 16");
  end

`ifdef ROM_PREFETCH_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PREFETCH} state_t;
`else
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
`endif

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic              discard_q, discard_d;
  logic              buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic              active;
  logic              hit;
  logic              pf_hit;
  logic              fill_ok;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] src_data;
  logic [7:0]        sel_byte;

  assign active  = ~bus.rom_ce_n & ~bus.rom_oe_n;
  assign tag     = bus.rom_addr[ADDR_W-1:1];
  assign hit     = buf_valid_q & (buf_tag_q == tag);
  // A fill is kept only if no invalidate arrived while it was in flight.
  assign fill_ok = ~(discard_q | bus.invalidate);

`ifdef ROM_PREFETCH_EN
  logic              pf_valid_q, pf_valid_d;
  logic [TAG_W-1:0]  pf_tag_q, pf_tag_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              pf_arm_q, pf_arm_d;
  logic [TAG_W-1:0]  next_tag;

  assign pf_hit   = pf_valid_q & (pf_tag_q == tag);
  assign next_tag = buf_tag_q + TAG_W'(1);
  // A prefetch hit is served straight from the pf entry during the cycle it is promoted.
  assign src_data = (~hit & pf_hit) ? pf_data_q : buf_data_q;
`else
  assign pf_hit   = 1'b0;
  assign src_data = buf_data_q;
`endif

  assign sel_byte     = bus.rom_addr[0] ? src_data[15:8] : src_data[7:0];
  assign bus.rom_q    = bus.rom_word ? src_data : {sel_byte, sel_byte};
  assign bus.busy     = rst_n & ((active & ~(hit | pf_hit)) | (state_q != ST_IDLE));
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // Next-state and buffer update logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    req_tag_d   = req_tag_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`ifdef ROM_PREFETCH_EN
    pf_valid_d  = pf_valid_q;
    pf_tag_d    = pf_tag_q;
    pf_data_d   = pf_data_q;
    pf_arm_d    = pf_arm_q;
`endif

    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (active && !hit && !pf_hit) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {tag, 1'b0};
          req_tag_d  = tag;
          state_d    = ST_WAIT;
        end
`ifdef ROM_PREFETCH_EN
        else if (active && !hit) begin
          buf_valid_d = 1'b1;
          buf_tag_d   = pf_tag_q;
          buf_data_d  = pf_data_q;
          pf_valid_d  = 1'b0;
          pf_arm_d    = 1'b1;
        end else if (pf_arm_q && !bus.invalidate) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {next_tag, 1'b0};
          req_tag_d  = next_tag;
          pf_arm_d   = 1'b0;
          state_d    = ST_PREFETCH;
        end
`endif
        if (bus.invalidate) begin
          buf_valid_d = 1'b0;
`ifdef ROM_PREFETCH_EN
          pf_valid_d  = 1'b0;
          pf_arm_d    = 1'b0;
`endif
        end
      end

      ST_WAIT: begin
        if (bus.invalidate) begin
          discard_d   = 1'b1;
          buf_valid_d = 1'b0;
`ifdef ROM_PREFETCH_EN
          pf_valid_d  = 1'b0;
`endif
        end
        if (bus.mem_ack) begin
          buf_data_d  = bus.mem_rdata;
          buf_tag_d   = req_tag_q;
          buf_valid_d = fill_ok;
          mem_req_d   = 1'b0;
          discard_d   = 1'b0;
          state_d     = ST_IDLE;
`ifdef ROM_PREFETCH_EN
          pf_arm_d    = fill_ok;
`endif
        end
      end

`ifdef ROM_PREFETCH_EN
      ST_PREFETCH: begin
        if (bus.invalidate) begin
          discard_d   = 1'b1;
          buf_valid_d = 1'b0;
          pf_valid_d  = 1'b0;
        end
        if (bus.mem_ack) begin
          pf_data_d  = bus.mem_rdata;
          pf_tag_d   = req_tag_q;
          pf_valid_d = fill_ok;
          mem_req_d  = 1'b0;
          discard_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // State and buffer registers
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      req_tag_q   <= '0;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
`ifdef ROM_PREFETCH_EN
      pf_valid_q  <= 1'b0;
      pf_tag_q    <= '0;
      pf_data_q   <= '0;
      pf_arm_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      req_tag_q   <= req_tag_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
`ifdef ROM_PREFETCH_EN
      pf_valid_q  <= pf_valid_d;
      pf_tag_q    <= pf_tag_d;
      pf_data_q   <= pf_data_d;
      pf_arm_q    <= pf_arm_d;
`endif
    end
  end
endmodule
